// File: rtl/aes_cbc_rx_chain.sv
// Receive-side AES-128 CBC chaining controller: feeds ciphertext blocks to an
// external inverse-cipher core and XORs each result with the chaining value.
module aes_cbc_rx_chain #(
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               msg_start,
  input  logic [BLOCK_W-1:0] iv,
  input  logic [BLOCK_W-1:0] key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_last,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_block,
  output logic [BLOCK_W-1:0] core_key,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_count,
  output logic               err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_CORE_REQ,
    S_CORE_WAIT,
    S_OUT_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic               last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    chain_d     = chain_q;
    key_d       = key_q;
    ct_d        = ct_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    err_d       = 1'b0;

    // A new message may only open from IDLE; anywhere else it is a violation.
    if (msg_start && (state_q != S_IDLE)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (msg_start) begin
          chain_d = iv;
          key_d   = key;
          cnt_d   = '0;
          state_d = S_WAIT_BLK;
        end
      end
      S_WAIT_BLK: begin
        if (in_valid) begin
          ct_d    = in_data;
          last_d  = in_last;
          state_d = S_CORE_REQ;
        end
      end
      S_CORE_REQ: begin
        tmo_d   = '0;
        state_d = S_CORE_WAIT;
      end
      S_CORE_WAIT: begin
        if (core_done) begin
          out_data_d  = core_result ^ chain_q;
          chain_d     = ct_q;
          out_last_d  = last_q;
          out_valid_d = 1'b1;
          state_d     = S_OUT_HOLD;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
          err_d       = 1'b1;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_OUT_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          cnt_d       = cnt_q + 1'b1;
          state_d     = out_last_q ? S_IDLE : S_WAIT_BLK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the wide data registers are reset too, because the core and
  // plaintext outputs are driven straight from them and must read 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      chain_q     <= '0;
      key_q       <= '0;
      ct_q        <= '0;
      out_data_q  <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      chain_q     <= chain_d;
      key_q       <= key_d;
      ct_q        <= ct_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign in_ready   = (state_q == S_WAIT_BLK);
  assign core_start = (state_q == S_CORE_REQ);
  assign core_block = ct_q;
  assign core_key   = key_q;
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign blk_count  = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_aes_cbc_rx_chain.sv
// Directed bench for aes_cbc_rx_chain with a behavioural inverse-cipher core
// whose latency and response are set per block.
module tb_aes_cbc_rx_chain;

  localparam int BW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          msg_start;
  logic [BW-1:0] iv, key;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          in_last;
  logic          core_start;
  logic [BW-1:0] core_block, core_key;
  logic          core_done;
  logic [BW-1:0] core_result;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] blk_count;
  logic          err;

  aes_cbc_rx_chain #(.BLOCK_W(BW), .CNT_W(CW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .msg_start(msg_start), .iv(iv), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_start(core_start), .core_block(core_block), .core_key(core_key),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .blk_count(blk_count), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural core: done pulses core_lat cycles after the core_start cycle.
  logic          core_mute = 1'b0;
  int            core_lat  = 10;
  logic [BW-1:0] core_resp = '0;

  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start && !core_mute) begin
        repeat (core_lat) @(posedge clk);
        #1 core_done = 1'b1;
        core_result  = core_resp;
        @(posedge clk);
        #1 core_done = 1'b0;
        core_result  = '0;
      end
    end
  end

  logic [BW-1:0] exp_key;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_outputs(input string tag);
    check({tag, "/in_ready"},   in_ready,   '0);
    check({tag, "/core_start"}, core_start, '0);
    check({tag, "/core_block"}, core_block, '0);
    check({tag, "/core_key"},   core_key,   '0);
    check({tag, "/out_valid"},  out_valid,  '0);
    check({tag, "/out_data"},   out_data,   '0);
    check({tag, "/out_last"},   out_last,   '0);
    check({tag, "/busy"},       busy,       '0);
    check({tag, "/blk_count"},  blk_count,  '0);
    check({tag, "/err"},        err,        '0);
  endtask

  task automatic start_msg(input logic [BW-1:0] iv_v, input logic [BW-1:0] key_v);
    msg_start = 1'b1;
    iv        = iv_v;
    key       = key_v;
    exp_key   = key_v;
    tick();
    msg_start = 1'b0;
  endtask

  // Offers one block, then checks the core request in the following cycle.
  task automatic send_block(input string tag, input logic [BW-1:0] ct, input logic last,
                            output int hs);
    logic ok;
    ok       = 1'b0;
    hs       = 0;
    in_valid = 1'b1;
    in_data  = ct;
    in_last  = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        hs = cyc;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "/in_accept"}, ok, 1'b1);
    @(negedge clk);
    check({tag, "/core_start"}, core_start, 1'b1);
    check({tag, "/core_block"}, core_block, ct);
    check({tag, "/core_key"},   core_key,   exp_key);
    tick();
  endtask

  task automatic wait_out(input string tag, output int oc);
    logic ok;
    ok = 1'b0;
    oc = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        oc = cyc;
      end else begin
        tick();
      end
    end
    check({tag, "/out_valid_seen"}, ok, 1'b1);
  endtask

  // Full block: send, await, check plaintext, optional backpressure, accept.
  task automatic run_block(input string tag, input logic [BW-1:0] ct, input logic last,
                           input logic [BW-1:0] resp, input int lat,
                           input logic [BW-1:0] exp_out, input int hold, input logic ms_on_accept);
    int hs, oc;
    logic [CW-1:0] cnt0;
    core_resp = resp;
    core_lat  = lat;
    send_block(tag, ct, last, hs);
    wait_out(tag, oc);
    check({tag, "/latency"},  oc - hs,  lat + 2);
    check({tag, "/out_data"}, out_data, exp_out);
    check({tag, "/out_last"}, out_last, last);
    cnt0 = blk_count;
    tick();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, out_valid, 1'b1);
      check({tag, "/hold_data"},  out_data,  exp_out);
      check({tag, "/hold_rdy"},   in_ready,  1'b0);
      check({tag, "/hold_cnt"},   blk_count, cnt0);
      tick();
    end
    out_ready = 1'b1;
    msg_start = ms_on_accept;
    iv        = {BW{1'b1}};
    tick();
    out_ready = 1'b0;
    msg_start = 1'b0;
    @(negedge clk);
    check({tag, "/cnt_step"}, blk_count, cnt0 + 1'b1);
    check({tag, "/valid_drop"}, out_valid, 1'b0);
    tick();
  endtask

  initial begin
    int hs, oc, ec;
    logic seen;

    rst = 1'b0; msg_start = 1'b0; iv = '0; key = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    exp_key = '0;
    repeat (2) @(posedge clk);
    #1;
    zero_outputs("reset");
    rst = 1'b1;
    tick();

    // in_valid while idle: not accepted, no error
    in_valid = 1'b1;
    in_data  = 128'h0123;
    @(negedge clk);
    check("idle_in/in_ready", in_ready, 1'b0);
    tick();
    @(negedge clk);
    check("idle_in/err", err, 1'b0);
    check("idle_in/busy", busy, 1'b0);
    tick();
    in_valid = 1'b0;

    // Single block, IV = 0
    start_msg('0, 128'h000102030405060708090a0b0c0d0e0f);
    @(negedge clk);
    check("t1/busy_on", busy, 1'b1);
    tick();
    run_block("t1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1,
              128'h00112233445566778899aabbccddeeff, 10,
              128'h00112233445566778899aabbccddeeff, 0, 1'b0);
    @(negedge clk);
    check("t1/busy_off", busy, 1'b0);
    check("t1/blk_count", blk_count, 16'd1);
    tick();

    // Single block, IV = all ones
    start_msg({BW{1'b1}}, 128'h000102030405060708090a0b0c0d0e0f);
    run_block("t2", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1,
              128'h00112233445566778899aabbccddeeff, 10,
              128'hffeeddccbbaa99887766554433221100, 0, 1'b0);
    @(negedge clk);
    check("t2/blk_count", blk_count, 16'd1);
    tick();

    // Two-block chain; msg_start lands on the final output handshake
    start_msg('0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_block("t3b0", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, '0, 4, '0, 0, 1'b0);
    @(negedge clk);
    check("t3/mid_busy", busy, 1'b1);
    check("t3/mid_rdy",  in_ready, 1'b1);
    tick();
    core_resp = '0;
    core_lat  = 4;
    send_block("t3b1", 128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b1, hs);
    wait_out("t3b1", oc);
    check("t3b1/out_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("t3b1/out_last", out_last, 1'b1);
    out_ready = 1'b1;
    msg_start = 1'b1;
    iv        = {BW{1'b1}};
    tick();
    out_ready = 1'b0;
    msg_start = 1'b0;
    @(negedge clk);
    check("t3/collide_err",  err,       1'b1);
    check("t3/collide_busy", busy,      1'b0);
    check("t3/blk_count",    blk_count, 16'd2);
    tick();
    @(negedge clk);
    check("t3/err_pulse", err, 1'b0);
    tick();

    // Backpressure: out_ready held low for 5 cycles
    start_msg('0, 128'h000102030405060708090a0b0c0d0e0f);
    run_block("t4", 128'h11112222333344445555666677778888, 1'b1,
              128'h0123456789abcdeffedcba9876543210, 6,
              128'h0123456789abcdeffedcba9876543210, 5, 1'b0);
    @(negedge clk);
    check("t4/blk_count", blk_count, 16'd1);
    tick();

    // Timeout: core never answers
    core_mute = 1'b1;
    start_msg('0, 128'h000102030405060708090a0b0c0d0e0f);
    send_block("t5", 128'hcafef00d, 1'b1, hs);
    seen = 1'b0;
    ec   = 0;
    for (int i = 0; i < 100 && ec == 0; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      if (err) ec = cyc;
      tick();
    end
    check("t5/err_cycle", ec - hs, 66);
    check("t5/no_valid",  seen, 1'b0);
    @(negedge clk);
    check("t5/err_pulse", err,  1'b0);
    check("t5/busy",      busy, 1'b0);
    check("t5/in_ready",  in_ready, 1'b0);
    tick();
    core_mute = 1'b0;

    // msg_start during CORE_WAIT: error, chain and key untouched
    start_msg(128'h000000000000000000000000000000ff, 128'h0f0e0d0c0b0a09080706050403020100);
    core_resp = 128'h11111111111111111111111111111100;
    core_lat  = 20;
    send_block("t6", 128'h99999999, 1'b1, hs);
    tick();
    tick();
    msg_start = 1'b1;
    iv        = 128'h123456789;
    key       = 128'habcdef;
    tick();
    msg_start = 1'b0;
    @(negedge clk);
    check("t6/err",  err,  1'b1);
    check("t6/busy", busy, 1'b1);
    tick();
    wait_out("t6", oc);
    check("t6/out_data", out_data, 128'h111111111111111111111111111111ff);
    check("t6/core_key", core_key, 128'h0f0e0d0c0b0a09080706050403020100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a core wait
    start_msg(128'h5a5a, 128'h77);
    core_resp = 128'hdead;
    core_lat  = 8;
    send_block("t7", 128'hbeef, 1'b1, hs);
    tick();
    #2 rst = 1'b0;
    #1 zero_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (err || out_valid || busy) seen = 1'b1;
      tick();
    end
    check("t7/stray_done_ignored", seen, 1'b0);

    // Fresh message after reset
    start_msg({64{2'b10}}, 128'h000102030405060708090a0b0c0d0e0f);
    run_block("t8", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1,
              {64{2'b01}}, 3, {BW{1'b1}}, 0, 1'b0);
    @(negedge clk);
    check("t8/blk_count", blk_count, 16'd1);
    check("t8/busy",      busy,      1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/aes_cbc_rx_chain.md
Name: aes_cbc_rx_chain

Overview:
- Receive-side CBC chaining controller: the decrypting counterpart of the encrypt path's IV + ciphertext output.
- Accepts an IV and key at message start, then a valid/ready stream of 128-bit ciphertext blocks.
- Drives an external single-block AES-128 inverse-cipher core through a start/done handshake.
- XORs each core result with the chaining value and emits plaintext blocks on a valid/ready stream, with a last marker and a block count.

Parameters:
BLOCK_W, 128, block/key/IV width (fixed for AES-128; parameterised for bench readability only)
CNT_W, 16, width of the per-message block counter
TIMEOUT, 64, max cycles in CORE_WAIT before abort; 0 disables

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
msg_start  in  1  one-cycle pulse: latch iv and key, open a message
iv  in  BLOCK_W  initialisation vector, sampled with msg_start
key  in  BLOCK_W  cipher key, sampled with msg_start
in_valid  in  1  ciphertext block valid
in_ready  out  1  controller can accept a block
in_data  in  BLOCK_W  ciphertext block
in_last  in  1  final block of message, qualified by in_valid
core_start  out  1  one-cycle request to inverse-cipher core
core_block  out  BLOCK_W  ciphertext to core, stable from core_start to core_done
core_key  out  BLOCK_W  latched key to core
core_done  in  1  one-cycle core completion pulse
core_result  in  BLOCK_W  core output, valid with core_done
out_valid  out  1  plaintext block valid
out_ready  in  1  downstream accepts
out_data  out  BLOCK_W  plaintext = core_result XOR chain value
out_last  out  1  final plaintext block
busy  out  1  high in any state other than IDLE
blk_count  out  CNT_W  blocks delivered in current message
err  out  1  one-cycle pulse on protocol violation or timeout

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0: in_ready, core_start, core_block, core_key, out_valid, out_data, out_last, busy, blk_count, err. Internal chain, key and ciphertext registers also 0.
- IDLE: in_ready=0. On msg_start: chain<=iv, key_reg<=key, blk_count<=0, go WAIT_BLK.
- WAIT_BLK: in_ready=1. On in_valid&in_ready: ct_reg<=in_data, last_reg<=in_last, go CORE_REQ.
- CORE_REQ: core_start=1 for exactly one cycle; core_block=ct_reg, core_key=key_reg; go CORE_WAIT.
- CORE_WAIT: on core_done, out_data<=core_result^chain, chain<=ct_reg, out_last<=last_reg, out_valid<=1, go OUT_HOLD. A timeout counter increments each cycle; if TIMEOUT!=0 and the count reaches TIMEOUT without core_done: err pulse, clear out_valid, go IDLE.
- OUT_HOLD: out_valid, out_data and out_last stay stable until out_ready. On handshake: out_valid<=0, blk_count<=blk_count+1 (wraps at 2^CNT_W). Then go IDLE if out_last, else WAIT_BLK.
- Latency: input handshake at cycle N -> core_start at N+1 -> core_done at N+1+L -> out_valid at N+2+L. One block in flight; no overlap.
- busy=1 in every state except IDLE. blk_count holds its value in IDLE until the next msg_start.
- Boundary and violation cases:
  - msg_start while busy: ignored, err pulse, state unchanged.
  - core_done outside CORE_WAIT: ignored, no err.
  - in_valid in IDLE: not accepted (in_ready=0), no err.
  - msg_start and the final out handshake in the same cycle: the handshake completes, msg_start is treated as "while busy" (err).
- Reset mid-operation: immediate return to IDLE with all outputs cleared; any block in flight is discarded.

Test Plan:
- Single block, IV=0, key=000102030405060708090a0b0c0d0e0f, in_data=69c4e0d86a7b0430d8cdb78070b4c55a, last=1. Core model returns 00112233445566778899aabbccddeeff after L=10. Required: core_start at N+1, out_data=00112233445566778899aabbccddeeff at N+12, out_last=1, blk_count=1, busy then 0.
- Same stimulus with IV=ffffffffffffffffffffffffffffffff -> out_data=ffeeddccbbaa99887766554433221100.
- Two-block chain, IV=0. Block 1 ct=69c4...c55a; core returns 0 for both blocks. Required: out0=0, out1=69c4e0d86a7b0430d8cdb78070b4c55a (chain = previous ct), blk_count=2.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, single blk_count increment on release.
- Timeout: TIMEOUT=64, core never answers -> err pulse 64 cycles after entering CORE_WAIT, out_valid never asserted, state IDLE, busy=0.
- Violation and reset: msg_start during CORE_WAIT -> err pulse, chain unchanged. Then rst=0 for 1 cycle -> every output 0 asynchronously. Then a fresh message decrypts correctly.
